// File: rtl/psum_temp_rf.sv
// psum_temp_rf: multi-channel partial-sum temporary register file.
// Load / saturating-accumulate writes, registered reads, handshaked drain.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   clr                 sync clear of all state (highest priority)
//   wr_en/wr_mode/      write strobe, 0=load 1=accumulate,
//   wr_addr/wr_data     entry and channel data (ch c at [c*DATA_W +: DATA_W])
//   rd_en/rd_addr       read strobe and entry
//   rd_data/rd_valid    registered read data, one-cycle valid pulse
//   drain_start         start streaming all entries out
//   out_data/out_valid  drain stream, out_ready accepts and zeroes entry
//   drain_done          one-cycle pulse after the last entry
//   busy                high while not IDLE
//   sat_flag            sticky per-channel saturation indicator
//
// Build option: define PSUM_CG_EN to clock each entry through a
// latch-based clock gate instead of enable muxes on a free clock.

module psum_temp_rf #(
    parameter int NUM_CH = 10,
    parameter int DATA_W = 20,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic                     wr_mode,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic                     rd_valid,
    input  logic                     drain_start,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     drain_done,
    output logic                     busy,
    output logic [NUM_CH-1:0]        sat_flag
);

    localparam int EW    = NUM_CH * DATA_W;
    localparam int AROWS = 2 ** ADDR_W;

    localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [EW-1:0] rd_data_q, rd_data_d;
    logic rd_valid_q, rd_valid_d;
    logic [NUM_CH-1:0] sat_q, sat_d;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];

    // Address-space view of storage: rows beyond DEPTH read as zero,
    // so out-of-range reads need no extra masking.
    logic [EW-1:0] row [AROWS];

    for (genvar i = 0; i < AROWS; i++) begin : g_row
        if (i < DEPTH) begin : g_real
            assign row[i] = mem_q[i];
        end else begin : g_pad
            assign row[i] = '0;
        end
    end

    // Saturating per-channel sum of the addressed entry and wr_data.
    logic [EW-1:0]     acc_src;
    logic [EW-1:0]     acc_word;
    logic [NUM_CH-1:0] acc_clamp;

    always_comb begin
        logic [DATA_W:0] sum;
        sum       = '0;
        acc_src   = row[wr_addr];
        acc_word  = '0;
        acc_clamp = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum = {acc_src[c*DATA_W+DATA_W-1], acc_src[c*DATA_W +: DATA_W]}
                + {wr_data[c*DATA_W+DATA_W-1], wr_data[c*DATA_W +: DATA_W]};
            // Top two bits disagree only when the true sum left range.
            if (sum[DATA_W] != sum[DATA_W-1]) begin
                acc_clamp[c] = 1'b1;
                acc_word[c*DATA_W +: DATA_W] = sum[DATA_W] ? S_MIN : S_MAX;
            end else begin
                acc_word[c*DATA_W +: DATA_W] = sum[DATA_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        sat_d      = sat_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (clr) begin
            state_d   = IDLE;
            ptr_d     = '0;
            rd_data_d = '0;
            sat_d     = '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Read sees mem_q, i.e. the pre-write value.
                    if (rd_en) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = row[rd_addr];
                    end
                    if (wr_en) begin
                        // Out-of-range addresses match no entry.
                        for (int i = 0; i < DEPTH; i++) begin
                            if (wr_addr == ADDR_W'(i)) begin
                                mem_d[i] = wr_mode ? acc_word : wr_data;
                                if (wr_mode) begin
                                    sat_d = sat_q | acc_clamp;
                                end
                            end
                        end
                    end
                    if (drain_start) begin
                        state_d = DRAIN;
                        ptr_d   = '0;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (ptr_q == ADDR_W'(i)) begin
                                mem_d[i] = '0;
                            end
                        end
                        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                            state_d = DONE;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            sat_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            sat_q      <= sat_d;
        end
    end

`ifdef PSUM_CG_EN
    logic first_q;
    logic [DEPTH-1:0] ent_en;
    logic [DEPTH-1:0] en_lat;
    logic [DEPTH-1:0] gclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q <= 1'b1;
        end else begin
            first_q <= 1'b0;
        end
    end

    // Gate opens only when an entry can actually change.
    always_comb begin
        ent_en = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_en[i] = clr | first_q
                | (state_q == IDLE && wr_en && wr_addr == ADDR_W'(i))
                | (state_q == DRAIN && out_ready && ptr_q == ADDR_W'(i));
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cg
        logic [EW-1:0] ent_q;

        // Enable captured while clk is low, so gclk never glitches.
        always_latch begin
            if (!clk) begin
                en_lat[i] = ent_en[i];
            end
        end

        assign gclk[i] = clk & en_lat[i];

        always_ff @(posedge gclk[i] or negedge rst_n) begin
            if (!rst_n) begin
                ent_q <= '0;
            end else begin
                ent_q <= mem_d[i];
            end
        end

        assign mem_q[i] = ent_q;
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end
`endif

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign out_data   = row[ptr_q];
    assign out_valid  = (state_q == DRAIN);
    assign drain_done = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign sat_flag   = sat_q;

endmodule
